// File: rtl/part2_dot_ctrl.sv
// -----------------------------------------------------------------------------
// part2_dot_ctrl
// Sequencer in front of an 8x8->16 multiply-accumulate unit. It collects one
// VEC_LEN-element int8 vector pair from a valid/ready stream, replays it to the
// MAC one pair per cycle with no bubbles, waits for every MAC valid_out, then
// returns the accumulated dot product and the MAC's overflow flag on a
// valid/ready result port. Once the result is taken it pulses mac_clear so the
// MAC accumulator starts from zero on the next job.
//
// Ports
//   clk, reset            clock (rising edge), synchronous active-high reset
//   s_a, s_b, s_valid     input element pair stream
//   s_ready               pair accepted while high (only in LOAD)
//   mac_a, mac_b          operands to the MAC
//   mac_valid             MAC valid_in
//   mac_clear             one-cycle pulse, ORed into the MAC reset
//   mac_f, mac_vout       MAC accumulator value and valid_out
//   mac_ovf               MAC sticky overflow
//   m_data, m_overflow    dot-product result and its overflow flag
//   m_valid, m_ready      result handshake
//
// Parameter VEC_LEN: elements per dot product, legal range 2..16.
// -----------------------------------------------------------------------------
module part2_dot_ctrl #(
    parameter int VEC_LEN = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [7:0]  s_a,
    input  logic signed [7:0]  s_b,
    input  logic               s_valid,
    output logic               s_ready,
    output logic signed [7:0]  mac_a,
    output logic signed [7:0]  mac_b,
    output logic               mac_valid,
    output logic               mac_clear,
    input  logic signed [15:0] mac_f,
    input  logic               mac_vout,
    input  logic               mac_ovf,
    output logic signed [15:0] m_data,
    output logic               m_overflow,
    output logic               m_valid,
    input  logic               m_ready
);

    // Buffer index width and a counter width that can also hold VEC_LEN itself.
    localparam int IW = (VEC_LEN > 2) ? $clog2(VEC_LEN) : 1;
    localparam int CW = $clog2(VEC_LEN + 1);

    localparam logic [IW-1:0] LAST_IDX = IW'(VEC_LEN - 1);
    localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
    localparam logic [IW-1:0] IDX_ONE  = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_FULL = CW'(VEC_LEN);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_LOAD   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_RESULT = 3'd3,
        ST_CLEAR  = 3'd4
    } state_t;

    state_t                state_q,      state_d;
    logic [IW-1:0]         wr_cnt_q,     wr_cnt_d;
    logic [CW-1:0]         rd_cnt_q,     rd_cnt_d;
    logic [CW-1:0]         vout_cnt_q,   vout_cnt_d;
    logic signed [7:0]     buf_a_q [VEC_LEN];
    logic signed [7:0]     buf_a_d [VEC_LEN];
    logic signed [7:0]     buf_b_q [VEC_LEN];
    logic signed [7:0]     buf_b_d [VEC_LEN];
    logic                  s_ready_q,    s_ready_d;
    logic signed [7:0]     mac_a_q,      mac_a_d;
    logic signed [7:0]     mac_b_q,      mac_b_d;
    logic                  mac_valid_q,  mac_valid_d;
    logic                  mac_clear_q,  mac_clear_d;
    logic signed [15:0]    m_data_q,     m_data_d;
    logic                  m_overflow_q, m_overflow_d;
    logic                  m_valid_q,    m_valid_d;

    // Next-state and next-output computation for the whole sequencer.
    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        vout_cnt_d   = vout_cnt_q;
        buf_a_d      = buf_a_q;
        buf_b_d      = buf_b_q;
        s_ready_d    = 1'b0;
        mac_a_d      = mac_a_q;
        mac_b_d      = mac_b_q;
        mac_valid_d  = 1'b0;
        mac_clear_d  = 1'b0;
        m_data_d     = m_data_q;
        m_overflow_d = m_overflow_q;
        m_valid_d    = m_valid_q;

        // MAC results can come back while the tail of the vector is still issuing.
        if (((state_q == ST_ISSUE) || (state_q == ST_DRAIN)) && mac_vout) begin
            vout_cnt_d = vout_cnt_q + CNT_ONE;
        end else begin
            vout_cnt_d = vout_cnt_q;
        end

        case (state_q)
            ST_LOAD: begin
                s_ready_d = 1'b1;
                if (s_valid && s_ready_q) begin
                    buf_a_d[wr_cnt_q] = s_a;
                    buf_b_d[wr_cnt_q] = s_b;
                    if (wr_cnt_q == LAST_IDX) begin
                        // Element 0 is already buffered (VEC_LEN >= 2), so the
                        // first issue can be registered on this same edge.
                        wr_cnt_d    = IDX_ZERO;
                        state_d     = ST_ISSUE;
                        s_ready_d   = 1'b0;
                        mac_valid_d = 1'b1;
                        mac_a_d     = buf_a_q[0];
                        mac_b_d     = buf_b_q[0];
                        rd_cnt_d    = CNT_ONE;
                    end else begin
                        wr_cnt_d = wr_cnt_q + IDX_ONE;
                    end
                end else begin
                    wr_cnt_d = wr_cnt_q;
                end
            end

            ST_ISSUE: begin
                if (rd_cnt_q == CNT_FULL) begin
                    rd_cnt_d = CNT_ZERO;
                    state_d  = ST_DRAIN;
                end else begin
                    mac_valid_d = 1'b1;
                    mac_a_d     = buf_a_q[rd_cnt_q[IW-1:0]];
                    mac_b_d     = buf_b_q[rd_cnt_q[IW-1:0]];
                    rd_cnt_d    = rd_cnt_q + CNT_ONE;
                end
            end

            ST_DRAIN: begin
                // The count is registered, so mac_f already holds the final
                // sum one cycle after the last valid_out.
                if (vout_cnt_q == CNT_FULL) begin
                    m_data_d     = mac_f;
                    m_overflow_d = mac_ovf;
                    m_valid_d    = 1'b1;
                    vout_cnt_d   = CNT_ZERO;
                    state_d      = ST_RESULT;
                end else begin
                    state_d = ST_DRAIN;
                end
            end

            ST_RESULT: begin
                if (m_valid_q && m_ready) begin
                    m_valid_d   = 1'b0;
                    mac_clear_d = 1'b1;
                    state_d     = ST_CLEAR;
                end else begin
                    state_d = ST_RESULT;
                end
            end

            ST_CLEAR: begin
                state_d   = ST_LOAD;
                s_ready_d = 1'b1;
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // State, buffer and registered-output flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_LOAD;
            wr_cnt_q     <= IDX_ZERO;
            rd_cnt_q     <= CNT_ZERO;
            vout_cnt_q   <= CNT_ZERO;
            for (int i = 0; i < VEC_LEN; i++) begin
                buf_a_q[i] <= 8'sd0;
                buf_b_q[i] <= 8'sd0;
            end
            s_ready_q    <= 1'b0;
            mac_a_q      <= 8'sd0;
            mac_b_q      <= 8'sd0;
            mac_valid_q  <= 1'b0;
            mac_clear_q  <= 1'b0;
            m_data_q     <= 16'sd0;
            m_overflow_q <= 1'b0;
            m_valid_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            vout_cnt_q   <= vout_cnt_d;
            buf_a_q      <= buf_a_d;
            buf_b_q      <= buf_b_d;
            s_ready_q    <= s_ready_d;
            mac_a_q      <= mac_a_d;
            mac_b_q      <= mac_b_d;
            mac_valid_q  <= mac_valid_d;
            mac_clear_q  <= mac_clear_d;
            m_data_q     <= m_data_d;
            m_overflow_q <= m_overflow_d;
            m_valid_q    <= m_valid_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign mac_a      = mac_a_q;
    assign mac_b      = mac_b_q;
    assign mac_valid  = mac_valid_q;
    assign mac_clear  = mac_clear_q;
    assign m_data     = m_data_q;
    assign m_overflow = m_overflow_q;
    assign m_valid    = m_valid_q;

endmodule

// File: tb/tb_part2_dot_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for part2_dot_ctrl (VEC_LEN = 4). A small MAC model (two-cycle
// latency, accumulator visible one cycle after valid_out, sticky overflow,
// cleared by reset or mac_clear) closes the loop. Expected results come from
// plain dot-product arithmetic on the job vectors.
// -----------------------------------------------------------------------------
module tb_part2_dot_ctrl;

    localparam int VEC = 4;

    logic               clk;
    logic               reset;
    logic signed [7:0]  s_a;
    logic signed [7:0]  s_b;
    logic               s_valid;
    logic               s_ready;
    logic signed [7:0]  mac_a;
    logic signed [7:0]  mac_b;
    logic               mac_valid;
    logic               mac_clear;
    logic signed [15:0] mac_f;
    logic               mac_vout;
    logic               mac_ovf;
    logic signed [15:0] m_data;
    logic               m_overflow;
    logic               m_valid;
    logic               m_ready;

    int total = 0;
    int bad   = 0;

    logic signed [7:0] ja [VEC];
    logic signed [7:0] jb [VEC];

    part2_dot_ctrl #(.VEC_LEN(VEC)) dut (
        .clk        (clk),
        .reset      (reset),
        .s_a        (s_a),
        .s_b        (s_b),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_valid  (mac_valid),
        .mac_clear  (mac_clear),
        .mac_f      (mac_f),
        .mac_vout   (mac_vout),
        .mac_ovf    (mac_ovf),
        .m_data     (m_data),
        .m_overflow (m_overflow),
        .m_valid    (m_valid),
        .m_ready    (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MAC environment model
    logic              mv1, mv2;
    int                mp1, mp2;
    logic signed [15:0] macc;
    logic              movf;

    function automatic logic out16(input int x);
        return (x > 32767) || (x < -32768);
    endfunction

    // Two-stage MAC pipeline; accumulates on the edge that ends the valid_out cycle.
    always @(posedge clk) begin
        if (reset || mac_clear) begin
            mv1  <= 1'b0;
            mv2  <= 1'b0;
            mp1  <= 0;
            mp2  <= 0;
            macc <= 16'sd0;
            movf <= 1'b0;
        end else begin
            mv1 <= mac_valid;
            mp1 <= int'(mac_a) * int'(mac_b);
            mv2 <= mv1;
            mp2 <= mp1;
            if (mv2) begin
                macc <= macc + mp2[15:0];
                movf <= movf | out16(int'(macc) + mp2);
            end
        end
    end

    assign mac_vout = mv2;
    assign mac_f    = macc;
    assign mac_ovf  = movf;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference dot product: running sum wrapped to 16 bits, overflow if any
    // partial sum leaves the signed 16-bit range.
    function automatic void ref_dot(output int d, output int o);
        int s;
        logic signed [15:0] w;
        s = 0;
        o = 0;
        for (int i = 0; i < VEC; i++) begin
            s = s + int'(ja[i]) * int'(jb[i]);
            if (s > 32767 || s < -32768) o = 1;
            w = s[15:0];
            s = int'(w);
        end
        d = s;
    endfunction

    task automatic set_job(input int a0, input int a1, input int a2, input int a3,
                           input int b0, input int b1, input int b2, input int b3);
        ja[0] = 8'(a0); ja[1] = 8'(a1); ja[2] = 8'(a2); ja[3] = 8'(a3);
        jb[0] = 8'(b0); jb[1] = 8'(b1); jb[2] = 8'(b2); jb[3] = 8'(b3);
    endtask

    // Runs one job starting at a negedge in LOAD; ends at the negedge of the next LOAD.
    task automatic run_job(input string name, input bit rand_valid, input int hold,
                           input bit junk, input bit check_time);
        int n_acc, cyc, runs, hold_left, exp_d, exp_o;
        bit hs, res_seen, prev_mv;
        logic signed [15:0] held_d;
        logic held_o;
        logic signed [7:0] iss_a [$];
        logic signed [7:0] iss_b [$];
        n_acc = 0; cyc = 0; runs = 0; hold_left = hold;
        hs = 0; res_seen = 0; prev_mv = 0;
        held_d = 16'sd0; held_o = 1'b0;
        ref_dot(exp_d, exp_o);
        while (!hs && cyc < 100) begin
            if (mac_valid) begin
                iss_a.push_back(mac_a);
                iss_b.push_back(mac_b);
            end
            if (mac_valid && !prev_mv) runs++;
            prev_mv = mac_valid;
            if (n_acc < VEC) begin
                s_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
                s_a = s_valid ? ja[n_acc] : 8'($urandom);
                s_b = s_valid ? jb[n_acc] : 8'($urandom);
                if (s_valid && s_ready) n_acc++;
            end else begin
                s_valid = junk;
                s_a = 8'($urandom);
                s_b = 8'($urandom);
            end
            if (m_valid) begin
                if (!res_seen) begin
                    res_seen = 1;
                    chk({name, "_data"}, m_data, exp_d);
                    chk({name, "_ovf"}, m_overflow, exp_o);
                    held_d = m_data;
                    held_o = m_overflow;
                end else begin
                    chk({name, "_hold_data"}, m_data, held_d);
                    chk({name, "_hold_ovf"}, m_overflow, held_o);
                end
                chk({name, "_res_sready"}, s_ready, 0);
                chk({name, "_res_clear"}, mac_clear, 0);
                if (hold_left > 0) begin
                    m_ready = 1'b0;
                    hold_left--;
                end else begin
                    m_ready = 1'b1;
                    hs = 1;
                end
            end else begin
                m_ready = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        chk({name, "_handshake"}, hs, 1);
        s_valid = 1'b0;
        m_ready = 1'b0;
        chk({name, "_clear_pulse"}, mac_clear, 1);
        chk({name, "_clear_mvalid"}, m_valid, 0);
        chk({name, "_clear_sready"}, s_ready, 0);
        @(negedge clk);
        chk({name, "_clear_once"}, mac_clear, 0);
        chk({name, "_reload_sready"}, s_ready, 1);
        chk({name, "_mac_pulses"}, iss_a.size(), VEC);
        chk({name, "_mac_runs"}, runs, 1);
        for (int i = 0; i < VEC; i++) begin
            if (i < iss_a.size()) begin
                chk({name, "_iss_a"}, iss_a[i], ja[i]);
                chk({name, "_iss_b"}, iss_b[i], jb[i]);
            end
        end
        if (check_time) chk({name, "_job_cycles"}, cyc, 2 * VEC + 4);
    endtask

    initial begin
        reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_a = 8'sd0; s_b = 8'sd0;
        repeat (2) @(negedge clk);
        chk("rst_sready", s_ready, 0);
        chk("rst_mac_valid", mac_valid, 0);
        chk("rst_mac_clear", mac_clear, 0);
        chk("rst_mac_a", mac_a, 0);
        chk("rst_mac_b", mac_b, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_ovf", m_overflow, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_sready", s_ready, 1);

        set_job(1, 2, 3, 4, 5, 6, 7, 8);
        run_job("basic", 1'b0, 0, 1'b0, 1'b1);

        set_job(127, 127, 127, 127, 127, 127, 127, 127);
        run_job("ovf", 1'b0, 0, 1'b0, 1'b1);

        set_job(1, 1, 1, 1, 1, 1, 1, 1);
        run_job("after_clear", 1'b0, 0, 1'b0, 1'b1);

        set_job(-128, -128, 1, -1, 127, 1, -1, 1);
        run_job("neg_hold", 1'b0, 6, 1'b1, 1'b0);

        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < VEC; i++) begin
                ja[i] = 8'($urandom);
                jb[i] = 8'($urandom);
            end
            run_job("rand", 1'b1, int'($urandom_range(0, 3)), 1'b1, 1'b0);
        end

        // Reset during the second ISSUE cycle discards the job.
        set_job(9, -3, 50, 7, 11, 4, -2, 100);
        for (int i = 0; i < VEC; i++) begin
            s_valid = 1'b1; s_a = ja[i]; s_b = jb[i];
            @(negedge clk);
        end
        s_valid = 1'b0;
        chk("issue1_valid", mac_valid, 1);
        @(negedge clk);
        chk("issue2_valid", mac_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_sready", s_ready, 0);
        chk("midrst_mac_valid", mac_valid, 0);
        chk("midrst_mac_clear", mac_clear, 0);
        chk("midrst_mac_a", mac_a, 0);
        chk("midrst_mac_b", mac_b, 0);
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_m_data", m_data, 0);
        chk("midrst_m_ovf", m_overflow, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_reload_sready", s_ready, 1);

        set_job(-7, 100, 3, -128, 2, -100, 33, 1);
        run_job("fresh", 1'b0, 0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
